// File: rtl/sm83_irq_arb.sv
// Interrupt flag capture, masked "nothing pending" NOR and fixed-priority
// request/acknowledge dispatch for the SM83 core (index 0 = highest priority).
module sm83_irq_arb #(
  parameter  int N_IRQ  = 5,
  parameter  int L_none = 21,
  localparam int VW     = $clog2(N_IRQ + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] req,
  input  logic [N_IRQ-1:0] ie,
  input  logic             ime,
  input  logic             wr_if,
  input  logic [N_IRQ-1:0] wdata,
  input  logic             ack,
  output logic [N_IRQ-1:0] if_q,
  output logic             pending,
  output logic             none,
  output logic             irq,
  output logic [VW-1:0]    vec_idx
);

  // Elmore delay model of the none net: N_IRQ series PMOS pull it up, one NMOS pulls it down.
  function automatic int r_pmos_ohm(input int w);
    return 12500 / w;
  endfunction

  function automatic int r_nmos_ohm(input int w);
    return 5000 / w;
  endfunction

  function automatic int tpd_elmore(input int load, input int r_ohm);
    return load * r_ohm;
  endfunction

  localparam int L_UNIT        = 1;
  localparam int NONE_TPD_RISE = tpd_elmore(L_none, r_pmos_ohm(5 * L_UNIT) * N_IRQ);
  localparam int NONE_TPD_FALL = tpd_elmore(L_none, r_nmos_ohm(5 * L_UNIT));

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    DISPATCH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] req_prev_q;
  logic [N_IRQ-1:0] flags_q, flags_d;
  logic [VW-1:0]    vec_q, vec_d;

  logic [N_IRQ-1:0] req_edge;
  logic [N_IRQ-1:0] masked;
  logic [N_IRQ-1:0] ack_masked;
  logic [N_IRQ-1:0] clr;
  logic [VW-1:0]    sel;
  logic [VW-1:0]    ack_sel;
  logic             do_clr;

  function automatic logic [VW-1:0] lowest_set(input logic [N_IRQ-1:0] v);
    logic [VW-1:0] r;
    r = VW'(N_IRQ);
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (v[i]) r = VW'(i);
    end
    return r;
  endfunction

  assign masked  = flags_q & ie;
  assign pending = |masked;
  assign none    = ~|masked;
  assign if_q    = flags_q;
  assign sel     = lowest_set(masked);

  // A same-cycle software write replaces the flags, so the acknowledged source
  // is chosen from the written value; writing the flag away yields the null vector.
  assign ack_masked = (wr_if ? wdata : flags_q) & ie;
  assign ack_sel    = lowest_set(ack_masked);

  for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_flag
    assign req_edge[gi] = req[gi] & ~req_prev_q[gi];
    assign clr[gi]      = do_clr && (ack_sel == VW'(gi));
    assign flags_d[gi]  = req_edge[gi] | (wr_if ? wdata[gi] : (flags_q[gi] & ~clr[gi]));
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    do_clr  = 1'b0;
    irq     = 1'b0;
    vec_idx = vec_q;
    case (state_q)
      IDLE: begin
        if (ime && (masked != '0)) state_d = ARMED;
      end
      ARMED: begin
        irq     = 1'b1;
        vec_idx = sel;
        if (ack) begin
          vec_d   = ack_sel;
          do_clr  = 1'b1;
          state_d = DISPATCH;
        end else if (!ime || (masked == '0)) begin
          state_d = IDLE;
        end
      end
      DISPATCH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_prev_q <= '0;
      flags_q    <= '0;
      vec_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_prev_q <= req;
      flags_q    <= flags_d;
      vec_q      <= vec_d;
    end
  end

endmodule

// File: tb/tb_sm83_irq_arb.sv
// Bench for sm83_irq_arb: directed vector table, async-reset sequence,
// 16-source build and randomized run against a behavioural flag/dispatch model.
module tb_sm83_irq_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] req, ie, wdata;
  logic       ime, wr_if, ack;
  logic [4:0] if_q;
  logic       pending, none, irq;
  logic [2:0] vec_idx;

  logic [15:0] req16, ie16, wdata16, if_q16;
  logic        ime16, wr_if16, ack16, pending16, none16, irq16;
  logic [4:0]  vec_idx16;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sm83_irq_arb #(.N_IRQ(5), .L_none(21)) dut (
    .clk(clk), .reset(reset), .req(req), .ie(ie), .ime(ime), .wr_if(wr_if),
    .wdata(wdata), .ack(ack), .if_q(if_q), .pending(pending), .none(none),
    .irq(irq), .vec_idx(vec_idx)
  );

  sm83_irq_arb #(.N_IRQ(16), .L_none(21)) dut16 (
    .clk(clk), .reset(reset), .req(req16), .ie(ie16), .ime(ime16), .wr_if(wr_if16),
    .wdata(wdata16), .ack(ack16), .if_q(if_q16), .pending(pending16), .none(none16),
    .irq(irq16), .vec_idx(vec_idx16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic [4:0] req;
    logic [4:0] ie;
    logic       ime;
    logic       wr_if;
    logic [4:0] wdata;
    logic       ack;
    logic [4:0] e_if;
    logic       e_irq;
    logic [2:0] e_vec;
    logic       e_pend;
  } row_t;

  function automatic row_t mk(input logic [4:0] r, input logic [4:0] e, input logic im,
                              input logic w, input logic [4:0] wd, input logic a,
                              input logic [4:0] xif, input logic xirq,
                              input logic [2:0] xvec, input logic xpend);
    row_t t;
    t.req = r; t.ie = e; t.ime = im; t.wr_if = w; t.wdata = wd; t.ack = a;
    t.e_if = xif; t.e_irq = xirq; t.e_vec = xvec; t.e_pend = xpend;
    return t;
  endfunction

  // Behavioural reference: flags, previous req and a dispatch phase (0 idle, 1 requesting, 2 dispatching).
  logic [4:0] m_flags, m_prev;
  int         m_phase, m_vec;

  function automatic int first_set(input logic [4:0] v);
    int k = 0;
    while (k < 5 && !v[k]) k++;
    return k;
  endfunction

  task automatic model_step();
    logic [4:0] rising, nf;
    int cleared = -1;
    int nphase = m_phase;
    rising = req & ~m_prev;
    if (m_phase == 0) begin
      if (ime && (m_flags & ie) != 0) nphase = 1;
    end else if (m_phase == 1) begin
      if (ack) begin
        m_vec = first_set((wr_if ? wdata : m_flags) & ie);
        if (m_vec < 5) cleared = m_vec;
        nphase = 2;
      end else if (!ime || (m_flags & ie) == 0) begin
        nphase = 0;
      end
    end else begin
      nphase = 0;
    end
    for (int b = 0; b < 5; b++) begin
      if (rising[b]) nf[b] = 1'b1;
      else if (wr_if) nf[b] = wdata[b];
      else if (b == cleared) nf[b] = 1'b0;
      else nf[b] = m_flags[b];
    end
    m_flags = nf;
    m_prev  = req;
    m_phase = nphase;
  endtask

  row_t tbl[21];

  initial begin
    tbl[0]  = mk(5'b00100, 5'h1f, 1, 0, 5'h00, 0, 5'b00100, 0, 3'd0, 1);
    tbl[1]  = mk(5'b00100, 5'h1f, 1, 0, 5'h00, 0, 5'b00100, 1, 3'd2, 1);
    tbl[2]  = mk(5'b00000, 5'h1f, 1, 0, 5'h00, 1, 5'b00000, 0, 3'd2, 0);
    tbl[3]  = mk(5'b00000, 5'h1f, 1, 0, 5'h00, 0, 5'b00000, 0, 3'd2, 0);
    tbl[4]  = mk(5'b00000, 5'h1f, 1, 1, 5'b01010, 0, 5'b01010, 0, 3'd2, 1);
    tbl[5]  = mk(5'b00000, 5'h1f, 1, 0, 5'h00, 0, 5'b01010, 1, 3'd1, 1);
    tbl[6]  = mk(5'b00000, 5'h1f, 1, 0, 5'h00, 1, 5'b01000, 0, 3'd1, 1);
    tbl[7]  = mk(5'b00000, 5'h1f, 1, 0, 5'h00, 0, 5'b01000, 0, 3'd1, 1);
    tbl[8]  = mk(5'b00000, 5'h1f, 1, 0, 5'h00, 0, 5'b01000, 1, 3'd3, 1);
    tbl[9]  = mk(5'b00000, 5'h1f, 1, 1, 5'b00001, 0, 5'b00001, 1, 3'd0, 1);
    tbl[10] = mk(5'b00000, 5'h1f, 1, 1, 5'b00000, 1, 5'b00000, 0, 3'd5, 0);
    tbl[11] = mk(5'b00000, 5'h1f, 1, 0, 5'h00, 0, 5'b00000, 0, 3'd5, 0);
    tbl[12] = mk(5'b00000, 5'b00001, 0, 1, 5'b00001, 0, 5'b00001, 0, 3'd5, 1);
    tbl[13] = mk(5'b00000, 5'b00001, 0, 0, 5'h00, 0, 5'b00001, 0, 3'd5, 1);
    tbl[14] = mk(5'b00000, 5'b00000, 0, 0, 5'h00, 0, 5'b00001, 0, 3'd5, 0);
    tbl[15] = mk(5'b00000, 5'h1f, 1, 0, 5'h00, 0, 5'b00001, 1, 3'd0, 1);
    tbl[16] = mk(5'b00000, 5'h1f, 1, 1, 5'b00100, 0, 5'b00100, 1, 3'd2, 1);
    tbl[17] = mk(5'b00100, 5'h1f, 1, 0, 5'h00, 1, 5'b00100, 0, 3'd2, 1);
    tbl[18] = mk(5'b00100, 5'h1f, 1, 0, 5'h00, 0, 5'b00100, 0, 3'd2, 1);
    tbl[19] = mk(5'b00100, 5'h1f, 1, 0, 5'h00, 0, 5'b00100, 1, 3'd2, 1);
    tbl[20] = mk(5'b00100, 5'h1f, 1, 1, 5'b01010, 1, 5'b01010, 0, 3'd1, 1);

    reset = 1'b0;
    req = 5'b00100; ie = 5'h1f; ime = 1'b1; wr_if = 1'b0; wdata = '0; ack = 1'b0;
    req16 = 16'h8000; ie16 = 16'hffff; ime16 = 1'b1; wr_if16 = 1'b0; wdata16 = '0; ack16 = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset if_q", 32'(if_q), 32'h0);
    chk("reset irq", 32'(irq), 32'h0);
    chk("reset vec_idx", 32'(vec_idx), 32'h0);
    chk("reset pending", 32'(pending), 32'h0);
    chk("reset none", 32'(none), 32'h1);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      req = tbl[i].req; ie = tbl[i].ie; ime = tbl[i].ime;
      wr_if = tbl[i].wr_if; wdata = tbl[i].wdata; ack = tbl[i].ack;
      @(posedge clk);
      #1;
      $display("row %0d: if_q=%b irq=%b vec=%0d pending=%b none=%b", i, if_q, irq, vec_idx, pending, none);
      chk($sformatf("row%0d if_q", i), 32'(if_q), 32'(tbl[i].e_if));
      chk($sformatf("row%0d irq", i), 32'(irq), 32'(tbl[i].e_irq));
      chk($sformatf("row%0d vec_idx", i), 32'(vec_idx), 32'(tbl[i].e_vec));
      chk($sformatf("row%0d pending", i), 32'(pending), 32'(tbl[i].e_pend));
      chk($sformatf("row%0d none", i), 32'(none), 32'(!tbl[i].e_pend));
      if (i == 1) begin
        chk("n16 if_q", 32'(if_q16), 32'h8000);
        chk("n16 irq", 32'(irq16), 32'h1);
        chk("n16 vec_idx", 32'(vec_idx16), 32'd15);
      end
      if (i < 20) @(negedge clk);
    end

    // Row 20 left the block in DISPATCH with flags 01010; reset must clear it before any edge.
    wr_if = 1'b0; ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    $display("async reset: if_q=%b irq=%b vec=%0d none=%b", if_q, irq, vec_idx, none);
    chk("async if_q", 32'(if_q), 32'h0);
    chk("async irq", 32'(irq), 32'h0);
    chk("async vec_idx", 32'(vec_idx), 32'h0);
    chk("async pending", 32'(pending), 32'h0);
    chk("async none", 32'(none), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset if_q", 32'(if_q), 32'b00100);
    chk("post-reset irq", 32'(irq), 32'h0);

    chk("none rise 16/5", 32'(dut16.NONE_TPD_RISE * 5), 32'(dut.NONE_TPD_RISE * 16));
    chk("none fall equal", 32'(dut16.NONE_TPD_FALL), 32'(dut.NONE_TPD_FALL));

    // Randomized run from a clean reset against the reference model.
    @(negedge clk);
    req = '0; ie = 5'h1f; ime = 1'b1; wr_if = 1'b0; ack = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    m_flags = '0; m_prev = '0; m_phase = 0; m_vec = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) req = req ^ 5'(1 << $urandom_range(0, 4));
      ie    = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'h1f;
      ime   = ($urandom_range(0, 6) != 0);
      wr_if = ($urandom_range(0, 9) == 0);
      wdata = 5'($urandom);
      ack   = ($urandom_range(0, 2) == 0);
      #1;
      chk($sformatf("rnd%0d if_q", c), 32'(if_q), 32'(m_flags));
      chk($sformatf("rnd%0d pending", c), 32'(pending), 32'((m_flags & ie) != 0));
      chk($sformatf("rnd%0d none", c), 32'(none), 32'((m_flags & ie) == 0));
      chk($sformatf("rnd%0d irq", c), 32'(irq), 32'(m_phase == 1));
      chk($sformatf("rnd%0d vec_idx", c), 32'(vec_idx),
          32'((m_phase == 1) ? first_set(m_flags & ie) : m_vec));
      model_step();
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
